pipe_sched: RTL and testbench
=============================

# pipe_sched

Round-robin scheduler that shares one `pipe_ex` arithmetic pipeline (four N-bit operands a, b, c, d in, one N-bit result f out, fixed latency, no stall input) between NREQ requesters. It arbitrates among requests and drives the winner's operands into the pipeline. A tag shift register tracks every in-flight operation, and each result is returned with the ID of the requester that issued it. It sits between the requester blocks and the `pipe_ex` instance; `pipe_ex` itself is unchanged.

## Interface
- `N`, 10, operand/result width (matches `pipe_ex` `n`)
- `NREQ`, 4, number of requesters (≥2)
- `LAT`, 3, clock edges from `pipe_ex` inputs changing to `f` valid (≥1)
- localparam `IDW` = `$clog2(NREQ)`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  request per requester, level
- `opnd`  in  4·N·NREQ  requester i operands at [4N·i +: 4N], packed {a,b,c,d}, a in the MSBs
- `gnt`  out  NREQ  one-hot, one-cycle grant pulse
- `busy`  out  NREQ  requester has an operation in flight
- `pa`, `pb`, `pc`, `pd`  out  N each  operands to `pipe_ex` a/b/c/d
- `pf`  in  N  `pipe_ex` output f
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_id`  out  IDW  requester index of the result
- `rsp_data`  out  N  result value

## Operation
- Eligibility: `elig = req & ~busy` (registered `busy`, pre-edge value).
- Round-robin pointer `ptr` (IDW bits):
  - The winner is the first eligible index scanning `ptr`, `ptr+1`, … modulo NREQ.
  - On a grant, `ptr <= winner+1`, wrapping NREQ-1 to 0.
  - With no grant, `ptr` holds.
- Grant edge, any `elig` bit set:
  - `pa..pd <= opnd[winner]`
  - `gnt <= onehot(winner)`
  - `busy[winner] <= 1`
  - tag stage 0 `<= {1, winner}`
- Edge with no eligible requester:
  - `gnt <= 0`
  - tag stage 0 valid `<= 0`
  - `pa..pd` hold their previous values (don't care)
- Tag pipeline: LAT stages of {valid, id} that shift every edge unconditionally.
- Completion edge, when stage LAT-1 is valid:
  - `rsp_valid <= 1`, `rsp_id <= stage id`, `rsp_data <= pf`
  - `busy[id] <= 0`
  - Otherwise `rsp_valid <= 0`; `rsp_id` and `rsp_data` hold.
- At most one operation per requester is in flight. Requesters must hold `req` and `opnd` stable until they see `gnt`, and must drop `req` in the `gnt` cycle unless they want another operation.
- Aggregate throughput: one issue per cycle across distinct requesters.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `gnt`, `busy`, `pa..pd`, `rsp_valid`, `rsp_id`, `rsp_data`, `ptr` and all tag stages go to 0.
- Grant decided at edge k: `gnt` and `pa..pd` are valid in the cycle after edge k.
- Result: `rsp_valid` is high in the cycle after edge k+LAT, with `rsp_data` = `pf` sampled at edge k+LAT.
- Busy window: `busy[i]` rises after edge k and falls after edge k+LAT. The earliest re-grant to the same requester is edge k+LAT+1, i.e. a per-requester period of LAT+1.
- A busy clear and a grant to a different requester at the same edge are both performed.
- The same requester cannot be cleared and re-granted at the same edge, because eligibility uses the pre-edge `busy`.
- Reset mid-operation: all in-flight tags are discarded, and no `rsp_valid` is produced for them.

## Test plan
Bench datapath model: `pf` = (`pa+pb+pc+pd`) delayed through a LAT-deep register chain, mod 2^N. Defaults N=10, NREQ=4, LAT=3.
- Single request: req0 = 1 with {10,12,6,3} at edge 1 after reset → `gnt`=0001 after edge 1; `pa..pd` = 10,12,6,3; `busy[0]` high for 3 cycles; `rsp_valid` after edge 4 with `rsp_id`=0, `rsp_data`=31.
- All four requesters at once: {10,10,5,3}, {20,11,1,4}, {15,10,8,2}, {8,15,5,0} on req0..3 → grants 0,1,2,3 on consecutive cycles; responses id 0,1,2,3 on consecutive cycles with data 28, 36, 35, 28.
- Fairness under load: req0 and req2 held high → grant sequence 0,2,idle,idle,0,2,…; neither requester is ever granted twice before the other.
- Re-grant spacing: req1 held high continuously → successive `gnt[1]` pulses exactly 4 cycles apart; `busy[1]` low for exactly one cycle between them.
- Pointer wrap: grant to 2 (ptr=3), then req0 and req3 both raised → req3 granted first, req0 next; overflow check {1000,30,1,4} returns 11 (1035 mod 1024).
- Reset mid-flight: `rst_n` pulsed low one cycle after a grant → `busy`, `gnt`, `pa..pd`, `rsp_*` all 0 immediately; no `rsp_valid` for 5 cycles after release while `req` is low.

Source files
------------

// File: rtl/pipe_sched.sv
// Round-robin issue scheduler sharing one fixed-latency pipe_ex pipeline among NREQ requesters,
// with a tag shift register that returns every result to the requester that issued it.
module pipe_sched #(
  parameter  int N    = 10,
  parameter  int NREQ = 4,
  parameter  int LAT  = 3,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [4*N*NREQ-1:0]   opnd,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       busy,
  output logic [N-1:0]          pa,
  output logic [N-1:0]          pb,
  output logic [N-1:0]          pc,
  output logic [N-1:0]          pd,
  input  logic [N-1:0]          pf,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [N-1:0]          rsp_data
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] NREQ_M1 = IDW'(NREQ - 1);

  logic [NREQ-1:0] gnt_q, gnt_d, busy_q, busy_d, elig_s;
  logic [IDW-1:0]  ptr_q, ptr_d, win_s;
  logic            any_s;
  logic [IDW:0]    idx_s;
  logic [4*N-1:0]  opnd_arr_s [NREQ];
  logic [4*N-1:0]  sel_s, ops_q, ops_d;
  logic [LAT-1:0]  tvld_q, tvld_d;
  logic [IDW-1:0]  tid_q [LAT];
  logic [IDW-1:0]  tid_d [LAT];
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;

  // Round-robin pick: scan downwards so the lowest offset from ptr is assigned last and wins.
  always_comb begin
    elig_s = req & ~busy_q;
    any_s  = |elig_s;
    win_s  = {IDW{1'b0}};
    idx_s  = {(IDW+1){1'b0}};
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx_s = {1'b0, ptr_q} + (IDW+1)'(j);
      if (idx_s >= NREQ_W) idx_s = idx_s - NREQ_W;
      else                 idx_s = idx_s;
      if (elig_s[idx_s[IDW-1:0]]) win_s = idx_s[IDW-1:0];
      else                        win_s = win_s;
    end
  end

  // Operand mux: unpack the flat operand bus per requester and select the winner's set.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      opnd_arr_s[i] = opnd[4*N*i +: 4*N];
    end
    sel_s = opnd_arr_s[win_s];
  end

  // Next state: tag shift, completion (clear busy, emit response), then issue.
  always_comb begin
    gnt_d     = {NREQ{1'b0}};
    ptr_d     = ptr_q;
    ops_d     = ops_q;
    busy_d    = busy_q;
    tvld_d[0] = any_s;
    tid_d[0]  = win_s;
    for (int i = 1; i < LAT; i++) begin
      tvld_d[i] = tvld_q[i-1];
      tid_d[i]  = tid_q[i-1];
    end
    if (tvld_q[LAT-1]) begin
      busy_d[tid_q[LAT-1]] = 1'b0;
      rsp_valid_d          = 1'b1;
      rsp_id_d             = tid_q[LAT-1];
      rsp_data_d           = pf;
    end else begin
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
    end
    // A same-edge clear/grant always targets different requesters because elig excludes busy.
    if (any_s) begin
      gnt_d[win_s]  = 1'b1;
      busy_d[win_s] = 1'b1;
      ops_d         = sel_s;
      ptr_d         = (win_s == NREQ_M1) ? {IDW{1'b0}} : win_s + IDW'(1);
    end else begin
      gnt_d = {NREQ{1'b0}};
      ptr_d = ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= {NREQ{1'b0}};
      busy_q      <= {NREQ{1'b0}};
      ptr_q       <= {IDW{1'b0}};
      ops_q       <= {(4*N){1'b0}};
      tvld_q      <= {LAT{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_data_q  <= {N{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        tid_q[i] <= {IDW{1'b0}};
      end
    end else begin
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      ops_q       <= ops_d;
      tvld_q      <= tvld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      for (int i = 0; i < LAT; i++) begin
        tid_q[i] <= tid_d[i];
      end
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign pa        = ops_q[4*N-1 -: N];
  assign pb        = ops_q[3*N-1 -: N];
  assign pc        = ops_q[2*N-1 -: N];
  assign pd        = ops_q[N-1:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched with a behavioural pipe_ex model
// (sum of the four operands, mod 2^N, returned LAT edges after issue).
module tb_pipe_sched;
  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [4*N*NREQ-1:0] opnd = '0;
  logic [NREQ-1:0]     gnt, busy;
  logic [N-1:0]        pa, pb, pc, pd, pf;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [N-1:0]        rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-edge values for the multi-requester scenarios.
  int s2_gnt [8]  = '{1, 2, 4, 8, 0, 0, 0, 0};
  int s2_rv  [8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
  int s2_id  [8]  = '{0, 0, 0, 0, 1, 2, 3, 0};
  int s2_dat [8]  = '{0, 0, 0, 28, 36, 35, 28, 0};
  int s3_gnt [10] = '{1, 4, 0, 0, 1, 4, 0, 0, 1, 4};
  int s3_rv  [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  int s3_id  [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 2, 0};
  int s4_g1  [9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int s4_b1  [9]  = '{1, 1, 1, 0, 1, 1, 1, 0, 1};

  pipe_sched #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opnd(opnd),
    .gnt(gnt), .busy(busy), .pa(pa), .pb(pb), .pc(pc), .pd(pd),
    .pf(pf), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // pipe_ex model: pa..pd act as its first stage, so LAT-1 further registers follow the adder.
  logic [N-1:0] sum_s;
  logic [N-1:0] dly [LAT-1];
  assign sum_s = pa + pb + pc + pd;
  assign pf    = dly[LAT-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT - 1; i++) dly[i] <= '0;
    end else begin
      dly[0] <= sum_s;
      for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] d);
    opnd[4*N*i +: 4*N] = {a, b, c, d};
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_pa", 32'(pa), 32'd0);

    // Single request from requester 0
    do_reset();
    set_op(0, 10'd10, 10'd12, 10'd6, 10'd3);
    req = 4'b0001;
    step();
    chk("s1_gnt", 32'(gnt), 32'd1);
    chk("s1_pa", 32'(pa), 32'd10);
    chk("s1_pb", 32'(pb), 32'd12);
    chk("s1_pc", 32'(pc), 32'd6);
    chk("s1_pd", 32'(pd), 32'd3);
    chk("s1_busy_e1", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    chk("s1_gnt_e2", 32'(gnt), 32'd0);
    chk("s1_busy_e2", 32'(busy), 32'd1);
    step();
    chk("s1_busy_e3", 32'(busy), 32'd1);
    chk("s1_rv_e3", 32'(rsp_valid), 32'd0);
    step();
    chk("s1_rv_e4", 32'(rsp_valid), 32'd1);
    chk("s1_id_e4", 32'(rsp_id), 32'd0);
    chk("s1_data_e4", 32'(rsp_data), 32'd31);
    chk("s1_busy_e4", 32'(busy), 32'd0);
    step();
    chk("s1_rv_e5", 32'(rsp_valid), 32'd0);
    chk("s1_hold_e5", 32'(rsp_data), 32'd31);

    // All four requesters at once, each dropping req in its grant cycle
    do_reset();
    set_op(0, 10'd10, 10'd10, 10'd5, 10'd3);
    set_op(1, 10'd20, 10'd11, 10'd1, 10'd4);
    set_op(2, 10'd15, 10'd10, 10'd8, 10'd2);
    set_op(3, 10'd8,  10'd15, 10'd5, 10'd0);
    req = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e <= 4) req[e-1] = 1'b0;
      chk($sformatf("s2_gnt_e%0d", e), 32'(gnt), 32'(s2_gnt[e-1]));
      chk($sformatf("s2_rv_e%0d", e), 32'(rsp_valid), 32'(s2_rv[e-1]));
      if (s2_rv[e-1] != 0) begin
        chk($sformatf("s2_id_e%0d", e), 32'(rsp_id), 32'(s2_id[e-1]));
        chk($sformatf("s2_data_e%0d", e), 32'(rsp_data), 32'(s2_dat[e-1]));
      end
    end

    // Fairness: req0 and req2 held high
    do_reset();
    req = 4'b0101;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("s3_gnt_e%0d", e), 32'(gnt), 32'(s3_gnt[e-1]));
      chk($sformatf("s3_rv_e%0d", e), 32'(rsp_valid), 32'(s3_rv[e-1]));
      if (s3_rv[e-1] != 0) chk($sformatf("s3_id_e%0d", e), 32'(rsp_id), 32'(s3_id[e-1]));
    end
    req = 4'b0000;

    // Re-grant spacing: req1 held high
    do_reset();
    req = 4'b0010;
    for (int e = 1; e <= 9; e++) begin
      step();
      chk($sformatf("s4_gnt1_e%0d", e), 32'(gnt[1]), 32'(s4_g1[e-1]));
      chk($sformatf("s4_busy1_e%0d", e), 32'(busy[1]), 32'(s4_b1[e-1]));
    end
    req = 4'b0000;

    // Pointer wrap and result overflow
    do_reset();
    set_op(2, 10'd1000, 10'd30, 10'd1, 10'd4);
    set_op(3, 10'd1, 10'd2, 10'd3, 10'd4);
    set_op(0, 10'd100, 10'd200, 10'd300, 10'd400);
    req = 4'b0100;
    step();
    chk("s5_gnt_e1", 32'(gnt), 32'd4);
    req = 4'b1001;
    step();
    chk("s5_gnt_e2", 32'(gnt), 32'd8);
    chk("s5_pa_e2", 32'(pa), 32'd1);
    req = 4'b0001;
    step();
    chk("s5_gnt_e3", 32'(gnt), 32'd1);
    req = 4'b0000;
    step();
    chk("s5_rv_e4", 32'(rsp_valid), 32'd1);
    chk("s5_id_e4", 32'(rsp_id), 32'd2);
    chk("s5_data_e4", 32'(rsp_data), 32'd11);
    step();
    chk("s5_id_e5", 32'(rsp_id), 32'd3);
    chk("s5_data_e5", 32'(rsp_data), 32'd10);
    step();
    chk("s5_id_e6", 32'(rsp_id), 32'd0);
    chk("s5_data_e6", 32'(rsp_data), 32'd1000);

    // Reset mid-flight
    do_reset();
    set_op(0, 10'd10, 10'd12, 10'd6, 10'd3);
    req = 4'b0001;
    step();
    chk("s6_gnt_e1", 32'(gnt), 32'd1);
    req = 4'b0000;
    step();
    rst_n = 1'b0;
    #1;
    chk("s6_gnt_rst", 32'(gnt), 32'd0);
    chk("s6_busy_rst", 32'(busy), 32'd0);
    chk("s6_pa_rst", 32'(pa), 32'd0);
    chk("s6_pb_rst", 32'(pb), 32'd0);
    chk("s6_pc_rst", 32'(pc), 32'd0);
    chk("s6_pd_rst", 32'(pd), 32'd0);
    chk("s6_rv_rst", 32'(rsp_valid), 32'd0);
    chk("s6_id_rst", 32'(rsp_id), 32'd0);
    chk("s6_data_rst", 32'(rsp_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("s6_rv_post_e%0d", e), 32'(rsp_valid), 32'd0);
      chk($sformatf("s6_busy_post_e%0d", e), 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
